fib_req_sequencer: RTL

// Upstream command stage for the fib calculator. It accepts n values over a

---
 rtl/fib_req_sequencer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fib_req_sequencer.sv
// -----------------------------------------------------------------------------
// fib_req_sequencer
//
// Command stage in front of the fib calculator. It takes n values from a
// valid/ready request channel and runs one fib go/n transaction at a time. Each
// outcome (result, overflow, or timeout) goes into a small response FIFO,
// tagged with a wrapping 8-bit sequence number. The FIFO drains over a
// valid/ready response channel.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active-low
//   req_valid     in   request present
//   req_ready     out  request accepted when req_valid && req_ready
//   req_n         in   requested n
//   fib_go        out  single-cycle go pulse to fib
//   fib_n         out  n to fib; holds from request handshake to next handshake
//   fib_result    in   fib result
//   fib_overflow  in   fib overflow
//   fib_done      in   fib done
//   rsp_valid     out  response FIFO non-empty
//   rsp_ready     in   response consumed when rsp_valid && rsp_ready
//   rsp_result    out  head result (0 on timeout)
//   rsp_overflow  out  head overflow flag
//   rsp_timeout   out  head timed out
//   rsp_tag       out  head sequence number (wraps 255 -> 0)
// -----------------------------------------------------------------------------
module fib_req_sequencer #(
  parameter int INPUT_WIDTH    = 6,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INPUT_WIDTH-1:0]  req_n,
  output logic                    fib_go,
  output logic [INPUT_WIDTH-1:0]  fib_n,
  input  logic [OUTPUT_WIDTH-1:0] fib_result,
  input  logic                    fib_overflow,
  input  logic                    fib_done,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUTPUT_WIDTH-1:0] rsp_result,
  output logic                    rsp_overflow,
  output logic                    rsp_timeout,
  output logic [7:0]              rsp_tag
);

  // Count must represent 0..RSP_DEPTH inclusive.
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_CAPTURE
  } state_t;

  typedef struct packed {
    logic [7:0]              tag;
    logic [OUTPUT_WIDTH-1:0] result;
    logic                    overflow;
    logic                    timeout;
  } entry_t;

  // Control path state
  state_t                  state_q, state_d;
  logic [INPUT_WIDTH-1:0]  fib_n_q, fib_n_d;
  logic                    go_q, go_d;
  logic                    req_ready_q, req_ready_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [OUTPUT_WIDTH-1:0] res_q, res_d;
  logic                    ovf_q, ovf_d;
  logic                    to_q, to_d;
  logic [7:0]              tag_q, tag_d;

  // Response FIFO state
  entry_t                  entry_q [RSP_DEPTH];
  entry_t                  entry_d [RSP_DEPTH];
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    rsp_valid_q, rsp_valid_d;

  logic                    req_fire;
  logic                    push;
  logic                    pop;
  entry_t                  push_entry;
  logic [CNT_W-1:0]        wr_idx;

  // req_ready_q is only ever 1 while in IDLE, so a handshake implies IDLE.
  assign req_fire = req_valid && req_ready_q && (state_q == S_IDLE);
  assign pop      = rsp_valid_q && rsp_ready;

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin : fsm_comb
    state_d = state_q;
    fib_n_d = fib_n_q;
    timer_d = timer_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    to_d    = to_q;
    tag_d   = tag_q;
    push    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          fib_n_d = req_n;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_ARM;
      end
      S_ARM: begin
        // fib_done may still show the previous transaction here; it is only
        // cleared by fib one cycle after go, so it is not looked at yet.
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fib_done) begin
          res_d   = fib_result;
          ovf_d   = fib_overflow;
          to_d    = 1'b0;
          state_d = S_CAPTURE;
        end else if (timer_q == TMR_LAST) begin
          res_d   = '0;
          ovf_d   = 1'b0;
          to_d    = 1'b1;
          state_d = S_CAPTURE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_CAPTURE: begin
        push    = 1'b1;
        tag_d   = tag_q + 8'd1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they come straight off flops
  // and read 0 during reset.
  always_comb begin : out_comb
    go_d        = (state_d == S_ISSUE);
    req_ready_d = (state_d == S_IDLE) && (count_d < DEPTH_C);
  end

  // ---------------------------------------------------------------------------
  // Response FIFO: shift-register organisation, entry 0 is always the head, so
  // the response outputs are taken directly from flops (show-ahead).
  // ---------------------------------------------------------------------------
  always_comb begin : fifo_comb
    push_entry          = '0;
    push_entry.tag      = tag_q;
    push_entry.result   = res_q;
    push_entry.overflow = ovf_q;
    push_entry.timeout  = to_q;

    entry_d = entry_q;
    // When popping, everything shifts down one, so the free slot is one lower.
    wr_idx  = pop ? (count_q - CNT_W'(1)) : count_q;

    if (pop) begin
      for (int i = 0; i < RSP_DEPTH - 1; i++) begin
        entry_d[i] = entry_q[i+1];
      end
      entry_d[RSP_DEPTH-1] = '0;
    end

    if (push) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        if (int'(wr_idx) == i) begin
          entry_d[i] = push_entry;
        end
      end
    end

    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    rsp_valid_d = (count_d != '0);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      fib_n_q     <= '0;
      go_q        <= 1'b0;
      req_ready_q <= 1'b0;
      timer_q     <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
      tag_q       <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fib_n_q     <= fib_n_d;
      go_q        <= go_d;
      req_ready_q <= req_ready_d;
      timer_q     <= timer_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      to_q        <= to_d;
      tag_q       <= tag_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign req_ready    = req_ready_q;
  assign fib_go       = go_q;
  assign fib_n        = fib_n_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = entry_q[0].result;
  assign rsp_overflow = entry_q[0].overflow;
  assign rsp_timeout  = entry_q[0].timeout;
  assign rsp_tag      = entry_q[0].tag;

  // Only one transaction is outstanding and req_ready accounts for FIFO
  // occupancy, so neither of these can happen.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    (push && !pop) |-> (count_q != DEPTH_C));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
    pop |-> (count_q != '0));

endmodule
